// File: rtl/puf_resp_uart_tx_pkg.sv
// Shared definitions for the PUF response UART transmitter.
// Contents:
//   PUF_UART_CLKS_PER_BIT - default clocks per UART bit (100 MHz / 115200 baud)
//   state_t               - FSM state encoding (3 bits) shared by the top level
//                           and the byte serialiser
package puf_resp_uart_tx_pkg;

    localparam int PUF_UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/puf_resp_uart_tx_byte.sv
// uart_tx_byte: serialises one byte as an 8N1 UART frame (start, 8 data bits
// LSB first, stop).
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   start - load data and begin a frame (accepted while ready is high)
//   data  - byte to send
//   tx    - serial line, idle high (registered)
//   ready - high while idle and during the final cycle of the stop bit, so a
//           start issued in that last cycle chains the next frame with no gap
module uart_tx_byte
    import puf_resp_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = PUF_UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        bit_r, bit_s;
    logic [7:0]        data_r, data_s;
    logic              tx_r, tx_s;
    logic              ready_r, ready_s;
    logic              baud_end_s;

    assign baud_end_s = (baud_r == BAUD_LAST);
    assign tx         = tx_r;
    assign ready      = ready_r;

    // Frame sequencing: next-state and next-output computation.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        data_s  = data_r;
        tx_s    = tx_r;
        ready_s = ready_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    data_s  = data;
                    tx_s    = 1'b0;
                    baud_s  = BAUD_ZERO;
                    ready_s = 1'b0;
                    state_s = ST_START;
                end else begin
                    tx_s    = 1'b1;
                    baud_s  = BAUD_ZERO;
                    ready_s = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_s  = BAUD_ZERO;
                    bit_s   = 3'd0;
                    tx_s    = data_r[0];
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s = BAUD_ZERO;
                    if (bit_r == 3'd7) begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end else begin
                        bit_s  = bit_r + 3'd1;
                        data_s = {1'b0, data_r[7:1]};
                        tx_s   = data_r[1];
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_s = BAUD_ZERO;
                    if (start) begin
                        data_s  = data;
                        tx_s    = 1'b0;
                        ready_s = 1'b0;
                        state_s = ST_START;
                    end else begin
                        tx_s    = 1'b1;
                        ready_s = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                    // Raise ready one cycle early so it is visible in the last stop cycle.
                    if (baud_r == BAUD_PRE) begin
                        ready_s = 1'b1;
                    end else begin
                        ready_s = ready_r;
                    end
                end
            end
            default: begin
                tx_s    = 1'b1;
                ready_s = 1'b0;
                baud_s  = BAUD_ZERO;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            data_r  <= 8'd0;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            tx_r    <= tx_s;
            ready_r <= ready_s;
        end
    end

endmodule

// File: rtl/puf_resp_uart_tx.sv
// puf_resp_uart_tx: on each rising edge of puf_done, captures the PUF response
// and sends it as NBYTES back-to-back 8N1 UART bytes, most-significant byte first.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   puf_out  - response word from the PUF generator
//   puf_done - level, response valid
//   tx       - UART serial line, idle high
//   busy     - high from capture until the last stop bit completes
//   tx_done  - one-cycle pulse after the final stop bit
//   byte_cnt - index of the byte currently on the line
module puf_resp_uart_tx
    import puf_resp_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = PUF_UART_CLKS_PER_BIT,
    parameter int RESP_W       = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RESP_W-1:0] puf_out,
    input  logic              puf_done,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [4:0]        byte_cnt
);

    localparam int         NBYTES    = RESP_W / 8;
    localparam logic [4:0] LAST_BYTE = 5'(NBYTES - 1);

    state_t            state_r, state_s;
    logic [RESP_W-1:0] shift_r, shift_s, shl_s;
    logic              done_q_r;
    logic              busy_r, busy_s;
    logic              tx_done_r, tx_done_s;
    logic [4:0]        cnt_r, cnt_s;
    logic              start_s;
    logic              byte_start_s;
    logic [7:0]        byte_data_s;
    logic              byte_ready_s;

    // A level already high at reset release still counts as an edge, since done_q resets low.
    assign start_s  = puf_done & ~done_q_r;
    assign shl_s    = shift_r << 8;
    assign busy     = busy_r;
    assign tx_done  = tx_done_r;
    assign byte_cnt = cnt_r;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .start(byte_start_s),
        .data (byte_data_s),
        .tx   (tx),
        .ready(byte_ready_s)
    );

    // Byte sequencing: capture, per-byte start issue and completion.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        busy_s       = busy_r;
        tx_done_s    = 1'b0;
        cnt_s        = cnt_r;
        byte_start_s = 1'b0;
        byte_data_s  = shift_r[RESP_W-1 -: 8];
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    shift_s = puf_out;
                    busy_s  = 1'b1;
                    state_s = ST_START;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_START: begin
                byte_start_s = 1'b1;
                state_s      = ST_DATA;
            end
            ST_DATA: begin
                // ready is high only in the last stop cycle here, so the next start chains gap-free.
                if (byte_ready_s) begin
                    shift_s = shl_s;
                    if (cnt_r == LAST_BYTE) begin
                        tx_done_s = 1'b1;
                        busy_s    = 1'b0;
                        cnt_s     = 5'd0;
                        state_s   = ST_DONE;
                    end else begin
                        byte_start_s = 1'b1;
                        byte_data_s  = shl_s[RESP_W-1 -: 8];
                        cnt_s        = cnt_r + 5'd1;
                    end
                end else begin
                    byte_start_s = 1'b0;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, capture register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            done_q_r  <= 1'b0;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
            cnt_r     <= 5'd0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            done_q_r  <= puf_done;
            busy_r    <= busy_s;
            tx_done_r <= tx_done_s;
            cnt_r     <= cnt_s;
        end
    end

endmodule

// File: tb/tb_puf_resp_uart_tx.sv
module tb_puf_resp_uart_tx;

    localparam int C     = 4;
    localparam int W     = 128;
    localparam int NB    = W / 8;
    localparam int FRAME = NB * 10 * C;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         puf_done = 1'b0;
    logic [W-1:0] puf_out  = '0;
    logic         tx, busy, tx_done;
    logic [4:0]   byte_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // UART line monitor results
    logic [7:0] rx_q[$];
    int         fall_q[$];
    int         cnt_q[$];
    int         frame_err = 0;
    int         busy_bad  = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;

    puf_resp_uart_tx #(.CLKS_PER_BIT(C), .RESP_W(W)) dut (
        .clk(clk), .rst(rst), .puf_out(puf_out), .puf_done(puf_done),
        .tx(tx), .busy(busy), .tx_done(tx_done), .byte_cnt(byte_cnt)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Decode the serial line by sampling mid-bit, relative to each falling edge.
    initial begin
        int         ph;
        logic [7:0] mb;
        ph = -1;
        mb = 8'h00;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                ph = -1;
            end else begin
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (ph < 0) begin
                    if (tx === 1'b0) begin
                        ph = 0;
                        fall_q.push_back(cyc);
                    end
                end else begin
                    ph++;
                    if (ph == C / 2) begin
                        cnt_q.push_back(int'(byte_cnt));
                        if (busy !== 1'b1 || tx !== 1'b0) busy_bad++;
                    end
                    if (ph >= C + C / 2 && ph <= 8 * C + C / 2 && ((ph - C / 2) % C) == 0)
                        mb[(ph - C / 2) / C - 1] = tx;
                    if (ph == 9 * C + C / 2) begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(mb);
                        ph = -1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        fall_q.delete();
        cnt_q.delete();
        frame_err = 0;
        busy_bad  = 0;
    endtask

    task automatic wait_cnt(input int n, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < FRAME + 100 && !hit; i++) begin
            @(negedge clk);
            if (byte_cnt === 5'(n)) hit = 1'b1;
        end
        chk(tag, W'(hit), W'(1));
    endtask

    // Wait for tx_done and compare the decoded frame with the expected word:
    // bytes MSB first, 10 bit times per byte, tx_done FRAME cycles after the first fall.
    task automatic expect_frame(input string tag, input logic [W-1:0] w,
                                input bit rearm, input logic [W-1:0] nxt);
        int           d0;
        bit           seen;
        bit           sp_ok;
        bit           cnt_ok;
        int           len;
        logic [W-1:0] rcv;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < FRAME + 400 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, W'(seen), W'(1));
        rcv = '0;
        foreach (rx_q[k]) rcv = {rcv[W-9:0], rx_q[k]};
        chk({tag, "_nbytes"}, W'(rx_q.size()), W'(NB));
        chk({tag, "_bytes"}, rcv, w);
        chk({tag, "_frame_err"}, W'(frame_err), W'(0));
        sp_ok  = (fall_q.size() == NB);
        cnt_ok = (cnt_q.size() == NB);
        foreach (fall_q[k]) if (fall_q[k] - fall_q[0] != k * 10 * C) sp_ok = 1'b0;
        foreach (cnt_q[k]) if (cnt_q[k] != k) cnt_ok = 1'b0;
        chk({tag, "_spacing"}, W'(sp_ok), W'(1));
        chk({tag, "_byte_cnt_seq"}, W'(cnt_ok), W'(1));
        len = (fall_q.size() > 0) ? (done_cyc - fall_q[0]) : -1;
        chk({tag, "_frame_len"}, W'(len), W'(FRAME));
        chk({tag, "_busy_during"}, W'(busy_bad), W'(0));
        chk({tag, "_busy_at_done"}, W'(busy), W'(0));
        chk({tag, "_cnt_at_done"}, W'(byte_cnt), W'(0));
        clear_mon();
        if (rearm) begin
            @(negedge clk);
            puf_out  = nxt;
            puf_done = 1'b1;
        end
    endtask

    initial begin
        int           c0;
        int           bad;
        int           d0;
        int           fl;
        logic [W-1:0] w;
        logic [W-1:0] alt;

        // 1. reset and quiet idle
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tx", W'(tx), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_tx_done", W'(tx_done), W'(0));
        chk("rst_byte_cnt", W'(byte_cnt), W'(0));
        rst = 1'b1;
        clear_mon();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_quiet", W'(bad), W'(0));
        chk("idle_no_frames", W'(fall_q.size() + done_cnt), W'(0));

        // 2. ASCII frame and start latency
        w       = 128'h5468697349734E6F74576F726B696E67;
        puf_out = w;
        @(negedge clk);
        c0       = cyc;
        puf_done = 1'b1;
        @(negedge clk);
        #1;
        chk("capture_busy", W'(busy), W'(1));
        chk("capture_tx_idle", W'(tx), W'(1));
        @(negedge clk);
        #1;
        chk("start_bit_low", W'(tx), W'(0));
        fl = (fall_q.size() > 0) ? (fall_q[0] - c0) : -1;
        chk("start_latency", W'(fl), W'(2));
        d0 = done_cnt;
        expect_frame("ascii", w, 1'b0, '0);
        repeat (200) @(negedge clk);
        chk("ascii_single_done", W'(done_cnt - d0), W'(1));
        chk("ascii_no_refire", W'(fall_q.size()), W'(0));
        puf_done = 1'b0;
        repeat (3) @(negedge clk);

        // 3. puf_done re-toggled mid-frame is ignored
        w        = 128'h0123456789ABCDEF_FEDCBA9876543210;
        puf_out  = w;
        puf_done = 1'b1;
        wait_cnt(5, "retoggle_reach5");
        puf_done = 1'b0;
        repeat (3) @(negedge clk);
        puf_done = 1'b1;
        d0 = done_cnt;
        expect_frame("retoggle", w, 1'b0, '0);
        repeat (300) @(negedge clk);
        chk("retoggle_no_second", W'(fall_q.size() + done_cnt - d0), W'(1));
        puf_done = 1'b0;
        repeat (3) @(negedge clk);

        // 4. random words, puf_out overwritten mid-frame
        for (int r = 0; r < 3; r++) begin
            w        = {$urandom, $urandom, $urandom, $urandom};
            puf_out  = w;
            @(negedge clk);
            puf_done = 1'b1;
            wait_cnt($urandom_range(1, 12), "rand_reach");
            puf_out = '1;
            expect_frame("rand_overwrite", w, 1'b0, '0);
            puf_done = 1'b0;
            repeat (5 + $urandom_range(0, 20)) @(negedge clk);
        end

        // 5. asynchronous reset during byte 7, then a full frame with puf_done held
        w        = {$urandom, $urandom, $urandom, $urandom};
        puf_out  = w;
        puf_done = 1'b1;
        wait_cnt(7, "reset_reach7");
        repeat ($urandom_range(1, 30)) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_tx", W'(tx), W'(1));
        chk("midreset_busy", W'(busy), W'(0));
        chk("midreset_cnt", W'(byte_cnt), W'(0));
        repeat (3) @(negedge clk);
        clear_mon();
        w       = {$urandom, $urandom, $urandom, $urandom};
        puf_out = w;
        rst     = 1'b1;
        wait_cnt(2, "post_reset_reach2");
        puf_done = 1'b0;

        // 6. back-to-back: rising edge one cycle after tx_done
        alt = {8{16'hFF00}};
        expect_frame("post_reset", w, 1'b1, alt);
        expect_frame("back_to_back", alt, 1'b0, '0);
        puf_done = 1'b0;
        repeat (100) @(negedge clk);
        chk("final_idle_tx", W'(tx), W'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
